// File: rtl/led_step_pkg.sv
// Shared definitions for the LED step counter: position width helper,
// end-behaviour mode constants and the step command encoding.
package led_step_pkg;

  // End behaviour selectors for the WRAP parameter
  localparam bit WRAP_MODE     = 1'b1;
  localparam bit SATURATE_MODE = 1'b0;

  // Arbitrated step command for the position register
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_e;

  // Position width: clog2 of the LED count, never narrower than one bit
  function automatic int pos_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_step_counter_button_conditioner.sv
// button_conditioner: 2-flop synchroniser, debounce, rising-edge detect and
// optional auto-repeat for one raw push button. Emits a single-cycle step pulse.
// Auto-repeat is built only when LED_STEP_AUTOREPEAT_EN is defined.
module button_conditioner
  import led_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_i,
  output logic step_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES <= 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_dly_q;
  logic             press_pulse;

  // Two-flop synchroniser for the asynchronous button pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], button_i};
  end

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync_q[1] == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = sync_q[1];
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state and one-cycle delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q     <= 1'b0;
      cnt_q     <= '0;
      deb_dly_q <= 1'b0;
    end else begin
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      deb_dly_q <= deb_q;
    end
  end

  // Press edge: only the rising edge of the debounced level produces a step
  assign press_pulse = deb_q & ~deb_dly_q;

`ifdef LED_STEP_AUTOREPEAT_EN
  localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] HOLD_LAST   = RPT_W'(HOLD_CYCLES);
  localparam logic [RPT_W-1:0] REPEAT_LAST = RPT_W'(REPEAT_CYCLES);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             repeating_q, repeating_d;
  logic             repeat_pulse;

  // Hold/repeat timing: counter holds cycles since the press edge (or last repeat)
  always_comb begin
    rpt_cnt_d    = rpt_cnt_q;
    repeating_d  = repeating_q;
    repeat_pulse = 1'b0;
    if (!deb_q) begin
      rpt_cnt_d   = '0;
      repeating_d = 1'b0;
    end else if ((!repeating_q && rpt_cnt_q == HOLD_LAST) ||
                 ( repeating_q && rpt_cnt_q == REPEAT_LAST)) begin
      repeat_pulse = 1'b1;
      rpt_cnt_d    = {{(RPT_W-1){1'b0}}, 1'b1};
      repeating_d  = 1'b1;
    end else begin
      rpt_cnt_d = rpt_cnt_q + 1'b1;
    end
  end

  // Auto-repeat state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_q   <= '0;
      repeating_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      repeating_q <= repeating_d;
    end
  end

  assign step_o = press_pulse | repeat_pulse;
`else
  // Hold/repeat timing has no meaning without auto-repeat
  logic unused_cfg;
  assign unused_cfg = ^{32'(HOLD_CYCLES), 32'(REPEAT_CYCLES)};

  assign step_o = press_pulse;
`endif

endmodule

// File: rtl/led_step_counter.sv
// led_step_counter: moves a single lit LED along an LED_COUNT-wide bar using
// two debounced push buttons, with wrap-around or saturating ends.
// Optional auto-repeat on long presses when LED_STEP_AUTOREPEAT_EN is defined.
module led_step_counter
  import led_step_pkg::*;
#(
  parameter int LED_COUNT       = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WRAP            = 1,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              button_inc,
  input  logic                              button_dec,
  output logic [LED_COUNT-1:0]              led,
  output logic [pos_width(LED_COUNT)-1:0]   position
);

  localparam int POS_W = pos_width(LED_COUNT);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(LED_COUNT - 1);
  localparam bit END_MODE = (WRAP != 0) ? WRAP_MODE : SATURATE_MODE;

  logic [1:0]           buttons;
  logic [1:0]           step;      // [0] = inc, [1] = dec
  step_e                step_cmd;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [LED_COUNT-1:0] led_q, led_d;

  assign buttons = {button_dec, button_inc};

  // One conditioner per button
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_cond (
        .clk      (clk),
        .rst_n    (reset),
        .button_i (buttons[gi]),
        .step_o   (step[gi])
      );
    end
  endgenerate

  // Arbitration: simultaneous up and down requests cancel
  always_comb begin
    step_cmd = STEP_NONE;
    if (step[0] && !step[1])      step_cmd = STEP_UP;
    else if (step[1] && !step[0]) step_cmd = STEP_DOWN;
  end

  // Next position with explicit end handling (safe for non-power-of-two counts)
  always_comb begin
    pos_d = pos_q;
    unique case (step_cmd)
      STEP_UP: begin
        if (pos_q == POS_MAX) pos_d = (END_MODE == WRAP_MODE) ? '0 : POS_MAX;
        else                  pos_d = pos_q + 1'b1;
      end
      STEP_DOWN: begin
        if (pos_q == '0) pos_d = (END_MODE == WRAP_MODE) ? POS_MAX : '0;
        else             pos_d = pos_q - 1'b1;
      end
      default: pos_d = pos_q;
    endcase
  end

  // One-hot decode of the next position so led and position update together
  generate
    for (gi = 0; gi < LED_COUNT; gi++) begin : g_dec
      assign led_d[gi] = (pos_d == POS_W'(gi));
    end
  endgenerate

  // Position and LED registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q <= '0;
      led_q <= {{(LED_COUNT-1){1'b0}}, 1'b1};
    end else begin
      pos_q <= pos_d;
      led_q <= led_d;
    end
  end

  assign position = pos_q;
  assign led      = led_q;

endmodule
